// File: rtl/dcf77_pkg.sv
// Shared DCF77 frame layout, field widths, time record and reset values
// used by the frame encoder, the generator and the decoder bench.
package dcf77_pkg;

  localparam int FRAME_LEN  = 59;
  localparam int FLAGS_LSB  = 15;
  localparam int START_TIME = 20;
  localparam int MIN_LSB    = 21;
  localparam int PAR_MIN    = 28;
  localparam int HOUR_LSB   = 29;
  localparam int PAR_HOUR   = 35;
  localparam int DATE_LSB   = 36;
  localparam int PAR_DATE   = 58;

  localparam int MIN_W   = 7;
  localparam int HOUR_W  = 6;
  localparam int DAY_W   = 6;
  localparam int WDAY_W  = 3;
  localparam int MONTH_W = 5;
  localparam int YEAR_W  = 8;
  localparam int FLAGS_W = 5;
  localparam int DATE_W  = DAY_W + WDAY_W + MONTH_W + YEAR_W;

  // Minute sits in the LSBs so the packed order matches transmission order.
  typedef struct packed {
    logic [YEAR_W-1:0]  year;
    logic [MONTH_W-1:0] month;
    logic [WDAY_W-1:0]  wday;
    logic [DAY_W-1:0]   day;
    logic [HOUR_W-1:0]  hour;
    logic [MIN_W-1:0]   min;
  } time_t;

  typedef logic [FRAME_LEN-1:0] frame_t;

  localparam time_t RESET_TIME = '{year: 8'h00, month: 5'h01, wday: 3'd1,
                                   day: 6'h01, hour: 6'h00, min: 7'h00};
  localparam logic [FLAGS_W-1:0] RESET_FLAGS = 5'b01000;

  // BCD minute advance with carry into the hour; the date is left alone.
  function automatic time_t next_minute(input time_t t);
    time_t r;
    r = t;
    if (t.min == 7'h59) begin
      r.min = '0;
      if (t.hour == 6'h23)
        r.hour = '0;
      else if (t.hour[3:0] == 4'h9)
        r.hour = {t.hour[5:4] + 2'd1, 4'h0};
      else
        r.hour[3:0] = t.hour[3:0] + 4'd1;
    end else if (t.min[3:0] == 4'h9) begin
      r.min = {t.min[6:4] + 3'd1, 4'h0};
    end else begin
      r.min[3:0] = t.min[3:0] + 4'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/dcf77_frame_encoder.sv
// Combinational assembly of a time record plus flag bits into the 59-bit
// DCF77 minute frame with even parity over minute, hour and date.
module dcf77_frame_encoder
  import dcf77_pkg::*;
(
  input  time_t               tm,
  input  logic [FLAGS_W-1:0]  flags,
  output frame_t              frame
);

  logic [DATE_W-1:0] date;

  assign date = {tm.year, tm.month, tm.wday, tm.day};

  always_comb begin
    frame = '0;
    frame[FLAGS_LSB +: FLAGS_W] = flags;
    frame[START_TIME]           = 1'b1;
    frame[MIN_LSB +: MIN_W]     = tm.min;
    frame[PAR_MIN]              = ^tm.min;
    frame[HOUR_LSB +: HOUR_W]   = tm.hour;
    frame[PAR_HOUR]             = ^tm.hour;
    frame[DATE_LSB +: DATE_W]   = date;
    frame[PAR_DATE]             = ^date;
  end

endmodule

// File: rtl/dcf77_frame_gen.sv
// DCF77 minute-frame generator: second/tick timing, pulse-width modulation
// of the encoded frame, a one-entry load shadow and optional minute advance.
module dcf77_frame_gen
  import dcf77_pkg::*;
#(
  parameter int TICKS_PER_SEC = 1000,
  parameter int SHORT_TICKS   = 100,
  parameter int LONG_TICKS    = 200,
  parameter int AUTO_INC      = 1,
  parameter int IDLE_LEVEL    = 1
) (
  input  logic                clk_in,
  input  logic                rst_n_in,
  input  logic                en_in,
  input  logic                load_valid_in,
  output logic                load_ready_out,
  input  logic [MIN_W-1:0]    min_in,
  input  logic [HOUR_W-1:0]   hour_in,
  input  logic [DAY_W-1:0]    day_in,
  input  logic [WDAY_W-1:0]   wday_in,
  input  logic [MONTH_W-1:0]  month_in,
  input  logic [YEAR_W-1:0]   year_in,
  input  logic [FLAGS_W-1:0]  flags_in,
  output logic                sgn_out,
  output logic [5:0]          sec_out,
  output logic                sec_tick_out,
  output logic                frame_start_out
);

  localparam int TW = $clog2(TICKS_PER_SEC);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICKS_PER_SEC - 1);
  localparam logic [TW-1:0] SHORT_W   = TW'(SHORT_TICKS);
  localparam logic [TW-1:0] LONG_W    = TW'(LONG_TICKS);
  localparam logic [5:0]    SEC_LAST  = 6'd59;
  localparam logic          IDLE      = 1'(IDLE_LEVEL);

  logic [TW-1:0]      tick_q, tick_d, pulse_len;
  logic [5:0]         sec_q, sec_d;
  logic               frame_edge, load_fire, inc_block_q;
  time_t              frame_q, shadow_q, load_tm;
  logic [FLAGS_W-1:0] flags_q, shadow_flags_q;
  logic               shadow_valid_q;
  frame_t             frame_bits;
  logic [63:0]        frame_pad;

  dcf77_frame_encoder u_encoder (
    .tm    (frame_q),
    .flags (flags_q),
    .frame (frame_bits)
  );

  assign frame_pad = {{(64 - FRAME_LEN){1'b0}}, frame_bits};
  assign load_tm   = {year_in, month_in, wday_in, day_in, hour_in, min_in};

  // load_valid_in/load_ready_out: a transfer happens on every clk_in edge
  // where both are high; ready depends only on the shadow being empty, and
  // valid may be raised or dropped at any time without protocol state.
  assign load_ready_out = ~shadow_valid_q;
  assign load_fire      = load_valid_in & ~shadow_valid_q;

  // Disabled: park in the pre-start state so the first enabled edge is a
  // frame start. At that edge the bit looked up is bit 0, which is constant
  // zero, so reading the not-yet-updated frame register is harmless.
  always_comb begin
    tick_d     = TICK_LAST;
    sec_d      = SEC_LAST;
    frame_edge = 1'b0;
    if (en_in) begin
      if (tick_q == TICK_LAST) begin
        tick_d     = '0;
        sec_d      = (sec_q == SEC_LAST) ? 6'd0 : sec_q + 6'd1;
        frame_edge = (sec_q == SEC_LAST);
      end else begin
        tick_d = tick_q + TW'(1);
        sec_d  = sec_q;
      end
    end
    pulse_len = '0;
    if (sec_d != SEC_LAST)
      pulse_len = frame_pad[sec_d] ? LONG_W : SHORT_W;
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      tick_q         <= TICK_LAST;
      sec_q          <= SEC_LAST;
      frame_q        <= RESET_TIME;
      flags_q        <= RESET_FLAGS;
      shadow_q       <= '0;
      shadow_flags_q <= '0;
      shadow_valid_q <= 1'b0;
      inc_block_q    <= 1'b1;
    end else begin
      tick_q <= tick_d;
      sec_q  <= sec_d;
      if (!en_in)
        inc_block_q <= 1'b1;
      else if (frame_edge)
        inc_block_q <= 1'b0;
      if (frame_edge) begin
        if (shadow_valid_q) begin
          frame_q <= shadow_q;
          flags_q <= shadow_flags_q;
        end else if (AUTO_INC != 0 && !inc_block_q) begin
          frame_q <= next_minute(frame_q);
        end
      end
      if (load_fire) begin
        shadow_q       <= load_tm;
        shadow_flags_q <= flags_in;
        shadow_valid_q <= 1'b1;
      end else if (frame_edge && shadow_valid_q) begin
        shadow_valid_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      sgn_out         <= IDLE;
      sec_out         <= '0;
      sec_tick_out    <= 1'b0;
      frame_start_out <= 1'b0;
    end else begin
      sgn_out         <= (en_in && (tick_d < pulse_len)) ? ~IDLE : IDLE;
      sec_out         <= en_in ? sec_d : 6'd0;
      sec_tick_out    <= en_in && (tick_d == '0);
      frame_start_out <= en_in && (tick_d == '0) && (sec_d == 6'd0);
    end
  end

endmodule

// File: doc/dcf77_frame_gen.md
Name: dcf77_frame_gen

Overview:
Parametrised DCF77 time-code generator for bench and demo use. It replaces the hard-wired fixed-pattern pulse source with a real frame encoder. It takes time and date as BCD through a valid/ready handshake and emits a correctly formed 59-bit DCF77 minute frame with parity. Second and frame strobes are provided for the decoder under test, and an optional auto-increment mode advances the time each minute.

Parameters:
TICKS_PER_SEC, 1000, clk_in cycles per second (min 300)
SHORT_TICKS, 100, active-pulse length for a 0 bit
LONG_TICKS, 200, active-pulse length for a 1 bit (> SHORT_TICKS, < TICKS_PER_SEC)
AUTO_INC, 1, 1 = advance minute/hour at each frame start when no new load is pending
IDLE_LEVEL, 1, sgn_out level between pulses; the pulse level is its inverse

Ports:
clk_in  in  1  clock
rst_n_in  in  1  asynchronous active-low reset
en_in  in  1  run enable
load_valid_in  in  1  time/date fields valid
load_ready_out  out  1  shadow register free
min_in  in  7  minute BCD
hour_in  in  6  hour BCD
day_in  in  6  day BCD
wday_in  in  3  weekday 1..7
month_in  in  5  month BCD
year_in  in  8  year BCD
flags_in  in  5  frame bits 15..19: call, DST-announce, CEST, CET, leap
sgn_out  out  1  DCF77 baseband output
sec_out  out  6  current second 0..59
sec_tick_out  out  1  one-cycle strobe at each second start
frame_start_out  out  1  one-cycle strobe at second 0

Behaviour:
- Reset (async, active-low):
  - sgn_out=IDLE_LEVEL, sec_out=0, strobes=0, load_ready_out=1, shadow empty.
  - Frame register = 00:00, day 01, wday 1, month 01, year 00, flags=00010 (CET).
  - Counters held in the pre-start state.
- Pre-start state: tick=TICKS_PER_SEC-1, sec=59. The first enabled edge wraps into second 0.
- Counting: tick increments while en_in=1. On wrap: tick=0 and sec=(sec==59)?0:sec+1.
- Output timing, for cycle k (0..TICKS_PER_SEC-1) of second s, all outputs registered:
  - sgn_out = ~IDLE_LEVEL for k < width(bit s), else IDLE_LEVEL.
  - width = LONG_TICKS if bit=1, else SHORT_TICKS.
  - Second 59 carries no pulse (minute marker).
  - sec_out=s throughout the second.
  - sec_tick_out=1 at k=0; frame_start_out=1 at k=0 when s=0.
- Frame bit map (even parity, LSB first):
  - 0=0; 1..14=0; 15..19=flags; 20=1.
  - 21..27 minute, 28 parity(21..27).
  - 29..34 hour, 35 parity(29..34).
  - 36..41 day, 42..44 wday, 45..49 month, 50..57 year, 58 parity(36..57).
- Load handshake:
  - Transfer on load_valid_in & load_ready_out. All fields and flags are captured into the shadow register.
  - load_ready_out = ~shadow_valid.
  - Inputs are not range-checked; they are transmitted as given.
- Frame-start edge (entry to second 0), in priority order:
  - Shadow valid: frame <= shadow, shadow cleared, ready returns to 1 on the next cycle.
  - Else if AUTO_INC: minute BCD+1; 59->00 carries into hour; hour 23->00. Date and flags are unchanged.
  - Else: frame unchanged.
- Simultaneous load and frame start with shadow empty: the new value goes to the shadow only. The current frame follows the no-load rule, and the new value is sent in the next minute.
- The frame register changes only at frame start. Parity is derived from the frame register, never from the shadow.
- en_in=0:
  - Synchronous return to the pre-start state.
  - Next cycle: sgn_out=IDLE_LEVEL, sec_out=0, strobes=0. Shadow is kept.
  - The frame start after re-enable performs the shadow transfer but suppresses auto-increment.
- Reset mid-pulse: output idles immediately and the frame register returns to its reset value.

Decomposition:
- dcf77_pkg holds:
  - Frame length (59), bit-index constants (START_TIME=20, MIN_LSB=21, PAR_MIN=28, HOUR_LSB=29, PAR_HOUR=35, DATE_LSB=36, PAR_DATE=58).
  - Field widths and the packed time_t struct.
  - Reset time constant.
- Sub-module dcf77_frame_encoder: combinational assembly of time_t+flags into the 59-bit vector with parity. Reused by the decoder bench's scoreboard.

Test Plan (TICKS_PER_SEC=1000, defaults):
1. Reset, en_in=1, no load.
   - Second 0: 100 low cycles. Seconds 18, 20, 36, 42, 45, 58: 200 low cycles. All others: 100.
   - Second 59: 1000 high cycles. frame_start_out=1 once per 60000 cycles.
2. Load 12:34 at second 10.
   - load_ready_out=0 until the next frame start. The current frame still reads 00:00.
   - Next frame: seconds 23, 25, 26, 28, 30, 33 are long; 35 is short.
3. Load 23:59.
   - Transmitted frame 23:59. The following frame is 00:00 with bits 28 and 35 short; the date is unchanged.
4. Load asserted on the frame-start edge with shadow empty.
   - That frame is the auto-incremented time. The loaded value appears one minute later.
5. en_in dropped during the second-5 pulse.
   - sgn_out=1 and sec_out=0 next cycle.
   - Re-enable: frame_start_out on the first edge, and the frame is not incremented.
6. rst_n_in pulsed low mid-pulse.
   - sgn_out=1 asynchronously, load_ready_out=1, frame returns to the reset time.
